// File: rtl/nfca_pkg.sv
// Shared definitions for the ISO 14443-A (106 kbit/s) reader-to-card modulator.
// Holds bit timing defaults, the Modified Miller sequence type and its encoder.
package nfca_pkg;

   localparam int BIT_CLKS_DEF   = 768;
   localparam int PAUSE_CLKS_DEF = 192;
   localparam int REQ_LEAD_DEF   = 4;
   localparam int CARRIER_DIV    = 6;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_X,
      SEQ_Y,
      SEQ_Z
   } seq_t;

   // Modified Miller: a 0 directly after a 1 must not pause at the period start,
   // otherwise the card would see two pauses closer than half a bit period.
   function automatic seq_t encode_bit(input logic en, input logic bit_val,
                                       input logic prev_one);
      seq_t s;
      if (!en)
         s = SEQ_IDLE;
      else if (bit_val)
         s = SEQ_X;
      else if (prev_one)
         s = SEQ_Y;
      else
         s = SEQ_Z;
      return s;
   endfunction

endpackage

// File: rtl/nfca_carrier_gen.sv
// Carrier divider and gate: clk/CARRIER_DIV square wave, forced low while gate=1.
// Only instantiated when NFCA_TX_CARRIER_EN is defined.
module nfca_carrier_gen
   import nfca_pkg::*;
(
   input  logic clk,
   input  logic rstn,
   input  logic gate,
   output logic carrier_out
);

   localparam int               PH_W    = $clog2(CARRIER_DIV);
   localparam logic [PH_W-1:0]  PH_LAST = PH_W'(CARRIER_DIV - 1);
   localparam logic [PH_W-1:0]  PH_HIGH = PH_W'(CARRIER_DIV / 2);

   logic [PH_W-1:0] phase;
   logic [PH_W-1:0] phase_nxt;
   logic            car_q;

   assign phase_nxt = (phase == PH_LAST) ? '0 : phase + PH_W'(1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         phase <= '0;
         car_q <= 1'b0;
      end else begin
         phase <= phase_nxt;
         car_q <= (phase_nxt < PH_HIGH);
      end
   end

   // Gating uses the registered pause directly so the carrier is off in exactly the pause cycles.
   assign carrier_out = car_q & ~gate;

endmodule

// File: rtl/nfca_tx_modulate.sv
// Modified Miller pause generator for NFC-A reader transmit, one bit per BIT_CLKS period.
// Optional carrier output is enabled by defining NFCA_TX_CARRIER_EN.
module nfca_tx_modulate
   import nfca_pkg::*;
#(
   parameter int BIT_CLKS   = BIT_CLKS_DEF,
   parameter int PAUSE_CLKS = PAUSE_CLKS_DEF,
   parameter int REQ_LEAD   = REQ_LEAD_DEF
) (
   input  logic clk,
   input  logic rstn,
   output logic tx_req,
   input  logic tx_en,
   input  logic tx_bit,
   output logic tx_pause,
   output logic carrier_out,
   output logic tx_busy,
   output logic tx_done
);

   localparam int             CW        = $clog2(BIT_CLKS);
   localparam logic [CW-1:0]  CNT_LAST  = CW'(BIT_CLKS - 1);
   localparam logic [CW-1:0]  REQ_AT    = CW'(BIT_CLKS - 1 - REQ_LEAD);
   localparam logic [CW-1:0]  HALF      = CW'(BIT_CLKS / 2);
   localparam logic [CW-1:0]  Z_END     = CW'(PAUSE_CLKS);
   localparam logic [CW-1:0]  X_END     = CW'(BIT_CLKS / 2 + PAUSE_CLKS);

   if (PAUSE_CLKS < 1 || PAUSE_CLKS > BIT_CLKS / 2 - 1) begin : g_bad_pause
      $error("nfca_tx_modulate: PAUSE_CLKS must be within 1..BIT_CLKS/2-1");
   end
   if (REQ_LEAD < 0 || REQ_LEAD > BIT_CLKS - 1) begin : g_bad_lead
      $error("nfca_tx_modulate: REQ_LEAD must be within 0..BIT_CLKS-1");
   end

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          armed;
   logic          wrap;
   seq_t          seq;
   seq_t          seq_nxt;
   logic          prev_bit;
   logic          prev_nxt;
   logic          req_nxt;
   logic          pause_nxt;
   logic          busy_nxt;
   logic          done_nxt;

   // armed holds cnt at 0 for the first clk after reset release.
   assign wrap = armed && (cnt == CNT_LAST);

   // NOTE: every flop here is updated with <= so all of them see the pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         armed    <= 1'b0;
         cnt      <= '0;
         seq      <= SEQ_IDLE;
         prev_bit <= 1'b0;
         tx_req   <= 1'b0;
         tx_pause <= 1'b0;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         armed    <= 1'b1;
         cnt      <= cnt_nxt;
         seq      <= seq_nxt;
         prev_bit <= prev_nxt;
         tx_req   <= req_nxt;
         tx_pause <= pause_nxt;
         tx_busy  <= busy_nxt;
         tx_done  <= done_nxt;
      end
   end

   // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latch).
   always_comb begin
      cnt_nxt  = cnt;
      seq_nxt  = seq;
      prev_nxt = prev_bit;
      if (armed)
         cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      if (wrap) begin
         seq_nxt  = encode_bit(tx_en, tx_bit, prev_bit);
         prev_nxt = tx_en & tx_bit;
      end
   end

   // Outputs are computed from next-state values so the registered copies line up with cnt.
   always_comb begin
      req_nxt   = (cnt_nxt == REQ_AT);
      pause_nxt = 1'b0;
      unique case (seq_nxt)
         SEQ_Z:   pause_nxt = (cnt_nxt < Z_END);
         SEQ_X:   pause_nxt = (cnt_nxt >= HALF) && (cnt_nxt < X_END);
         default: pause_nxt = 1'b0;
      endcase
      busy_nxt = tx_busy;
      if (wrap)
         busy_nxt = (seq_nxt != SEQ_IDLE) || (seq != SEQ_IDLE);
      done_nxt = tx_busy & ~busy_nxt;
   end

`ifdef NFCA_TX_CARRIER_EN
   nfca_carrier_gen u_carrier (
      .clk         (clk),
      .rstn        (rstn),
      .gate        (tx_pause),
      .carrier_out (carrier_out)
   );
`else
   assign carrier_out = 1'b0;
`endif

endmodule

// File: tb/tb_nfca_tx_modulate.sv
// Scoreboard bench for nfca_tx_modulate: per-period expectations are queued when
// bits are driven and compared when the period completes on the DUT outputs.
module tb_nfca_tx_modulate;

   localparam int BC      = 768;
   localparam int PC      = 192;
   localparam int HALF    = BC / 2;
   localparam int REQ_POS = BC - 1 - 4;

   logic clk    = 1'b0;
   logic rstn   = 1'b0;
   logic tx_en  = 1'b0;
   logic tx_bit = 1'b0;
   logic tx_req;
   logic tx_pause;
   logic carrier_out;
   logic tx_busy;
   logic tx_done;

   always #5 clk = ~clk;

   nfca_tx_modulate #(
      .BIT_CLKS   (BC),
      .PAUSE_CLKS (PC),
      .REQ_LEAD   (4)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .tx_req      (tx_req),
      .tx_en       (tx_en),
      .tx_bit      (tx_bit),
      .tx_pause    (tx_pause),
      .carrier_out (carrier_out),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done)
   );

   typedef struct {
      string tag;
      int    period;
      int    pst;
      int    pw;
      bit    busy;
      bit    done;
   } exp_t;

   exp_t exp_q[$];
   int   plog[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   // Clock edges since reset release; expected cnt is (cyc-1) % BC once cyc >= 1.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   int   m_c, m_p, m_pst, m_pw, m_runs, m_rq, m_rqpos, m_dn, m_dpos, m_car, m_carp, m_expcar;
   bit   m_busy0, m_bvar, m_last_pause;
   exp_t m_e;

   always @(negedge clk) begin
      if (!rstn) begin
         exp_q.delete();
         m_last_pause = 1'b0;
      end else if (cyc >= 1) begin
         m_c = (cyc - 1) % BC;
         m_p = (cyc - 1) / BC;
         if (m_c == 0) begin
            m_pst = -1; m_pw = 0; m_runs = 0; m_rq = 0; m_rqpos = -1;
            m_dn = 0; m_dpos = -1; m_car = 0; m_carp = 0;
            m_busy0 = tx_busy; m_bvar = 1'b0;
         end
         if (tx_pause) begin
            if (m_pst < 0) m_pst = m_c;
            m_pw++;
            if (!m_last_pause) begin
               m_runs++;
               plog.push_back(cyc);
            end
         end
         m_last_pause = tx_pause;
         if (tx_busy !== m_busy0) m_bvar = 1'b1;
         if (tx_req)  begin m_rq++; m_rqpos = m_c; end
         if (tx_done) begin m_dn++; m_dpos = m_c; end
         if (carrier_out) begin
            m_car++;
            if (tx_pause) m_carp++;
         end
         if (m_c == BC - 1 && exp_q.size() > 0) begin
            if (exp_q[0].period < m_p) begin
               m_e = exp_q.pop_front();
               n_cmp++; n_bad++;
               $display("FAIL %s period_missed: period %0d not observed, now at period %0d",
                        m_e.tag, m_e.period, m_p);
            end else if (exp_q[0].period == m_p) begin
               m_e = exp_q.pop_front();
`ifdef NFCA_TX_CARRIER_EN
               m_expcar = HALF - m_e.pw / 2;
`else
               m_expcar = 0;
`endif
               n_cmp++;
               if (m_pst !== m_e.pst || m_pw !== m_e.pw || m_runs !== ((m_e.pst >= 0) ? 1 : 0)) begin
                  n_bad++;
                  $display("FAIL %s p%0d pause: got start=%0d width=%0d runs=%0d, want start=%0d width=%0d",
                           m_e.tag, m_p, m_pst, m_pw, m_runs, m_e.pst, m_e.pw);
               end
               n_cmp++;
               if (m_busy0 !== m_e.busy || m_bvar) begin
                  n_bad++;
                  $display("FAIL %s p%0d busy: got %0b (varied=%0b), want %0b steady",
                           m_e.tag, m_p, m_busy0, m_bvar, m_e.busy);
               end
               n_cmp++;
               if (m_rq !== 1 || m_rqpos !== REQ_POS) begin
                  n_bad++;
                  $display("FAIL %s p%0d tx_req: got %0d pulses last at %0d, want 1 at %0d",
                           m_e.tag, m_p, m_rq, m_rqpos, REQ_POS);
               end
               n_cmp++;
               if (m_dn !== int'(m_e.done) || (m_e.done && m_dpos !== 0)) begin
                  n_bad++;
                  $display("FAIL %s p%0d tx_done: got %0d pulses at %0d, want %0d at 0",
                           m_e.tag, m_p, m_dn, m_dpos, m_e.done);
               end
               n_cmp++;
               if (m_car !== m_expcar || m_carp !== 0) begin
                  n_bad++;
                  $display("FAIL %s p%0d carrier: got %0d high (%0d in pause), want %0d (0 in pause)",
                           m_e.tag, m_p, m_car, m_carp, m_expcar);
               end
            end
         end
      end
   end

   task automatic wait_cnt(input int target);
      bit found = 1'b0;
      for (int i = 0; i < 2 * BC && !found; i++) begin
         @(negedge clk);
         if (rstn && cyc >= 1 && (cyc - 1) % BC == target) found = 1'b1;
      end
      if (!found) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_cnt: cnt %0d not reached, want it within %0d cycles", target, 2 * BC);
      end
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 12 * BC && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_cmp++; n_bad++;
         $display("FAIL %s drain: %0d expectations left, want 0", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   function automatic exp_t mk(input string tag, input int period, input int pst,
                               input int pw, input bit busy, input bit done);
      exp_t e;
      e.tag = tag; e.period = period; e.pst = pst; e.pw = pw; e.busy = busy; e.done = done;
      return e;
   endfunction

   // Drives n bits (bits[0] first) one per period and queues the Modified Miller expectations.
   task automatic send_frame(input string tag, input int n, input logic [15:0] bits,
                             input bit toggle);
      bit prev_m = 1'b0;
      int p;
      for (int i = 0; i < n; i++) begin
         wait_cnt(BC - 3);
         p      = (cyc - 1) / BC;
         tx_en  = 1'b1;
         tx_bit = bits[i];
         if (bits[i])     exp_q.push_back(mk(tag, p + 1, HALF, PC, 1'b1, 1'b0));
         else if (prev_m) exp_q.push_back(mk(tag, p + 1, -1, 0, 1'b1, 1'b0));
         else             exp_q.push_back(mk(tag, p + 1, 0, PC, 1'b1, 1'b0));
         prev_m = bits[i];
         if (toggle) begin
            wait_cnt(200);
            tx_bit = ~tx_bit;
         end
      end
      wait_cnt(BC - 3);
      p      = (cyc - 1) / BC;
      tx_en  = 1'b0;
      tx_bit = 1'($urandom_range(0, 1));
      exp_q.push_back(mk(tag, p + 1, -1, 0, 1'b1, 1'b0));
      exp_q.push_back(mk(tag, p + 2, -1, 0, 1'b0, 1'b1));
      exp_q.push_back(mk(tag, p + 3, -1, 0, 1'b0, 1'b0));
      drain(tag);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if ({tx_req, tx_pause, tx_busy, tx_done, carrier_out} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: got req,pause,busy,done,car=%05b, want 00000",
                  {tx_req, tx_pause, tx_busy, tx_done, carrier_out});
      end
      rstn = 1'b1;
   endtask

   task automatic test_idle();
      int p;
      tx_en = 1'b0;
      wait_cnt(0);
      p = (cyc - 1) / BC;
      for (int k = 1; k <= 5; k++) begin
         tx_bit = 1'($urandom_range(0, 1));
         exp_q.push_back(mk("idle", p + k, -1, 0, 1'b0, 1'b0));
      end
      drain("idle");
   endtask

   task automatic test_carrier();
      int hi = 0;
`ifdef NFCA_TX_CARRIER_EN
      int t0 = -1;
      int edges = 0;
      bit last;
      wait_cnt(10);
      last = carrier_out;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (carrier_out && !last) begin
            if (t0 >= 0) begin
               n_cmp++;
               if (i - t0 !== 6) begin
                  n_bad++;
                  $display("FAIL carrier_period: got %0d cycles between rises, want 6", i - t0);
               end
            end
            t0 = i;
            edges++;
         end
         if (carrier_out) hi++;
         last = carrier_out;
      end
      n_cmp++;
      if (edges < 9 || hi !== 30) begin
         n_bad++;
         $display("FAIL carrier_duty: got %0d rises and %0d high cycles in 60, want >=9 and 30",
                  edges, hi);
      end
`else
      wait_cnt(10);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (carrier_out !== 1'b0) hi++;
      end
      n_cmp++;
      if (hi !== 0) begin
         n_bad++;
         $display("FAIL carrier_tied: got %0d non-zero cycles, want 0", hi);
      end
`endif
   endtask

   task automatic test_frame_zxyzz();
      send_frame("zxyzz", 5, 16'h0002, 1'b0);
   endtask

   task automatic test_xx_spacing();
      plog.delete();
      send_frame("zxxy", 4, 16'h0006, 1'b0);
      n_cmp++;
      if (plog.size() !== 3) begin
         n_bad++;
         $display("FAIL xx_spacing: got %0d pauses, want 3", plog.size());
      end else if (plog[2] - plog[1] !== BC || plog[1] - plog[0] !== BC + HALF) begin
         n_bad++;
         $display("FAIL xx_spacing: got gaps %0d,%0d, want %0d,%0d",
                  plog[1] - plog[0], plog[2] - plog[1], BC + HALF, BC);
      end
   endtask

   task automatic test_sample_hold();
      send_frame("hold", 3, 16'h0005, 1'b1);
   endtask

   task automatic test_one_bit();
      send_frame("one_bit", 1, 16'h0000, 1'b0);
   endtask

   task automatic test_reset_mid();
      int  n = 0;
      bit  found = 1'b0;
      int  bad_cycles = 0;
      wait_cnt(BC - 3);
      tx_en  = 1'b1;
      tx_bit = 1'b0;
      wait_cnt(100);
      n_cmp++;
      if (tx_pause !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid_pre: got tx_pause=%0b at cnt 100 of Z, want 1", tx_pause);
      end
      rstn = 1'b0;
      #1;
      n_cmp++;
      if ({tx_pause, tx_busy, tx_done, tx_req, carrier_out} !== 5'b0) begin
         n_bad++;
         $display("FAIL rst_mid_async: got pause,busy,done,req,car=%05b, want 00000",
                  {tx_pause, tx_busy, tx_done, tx_req, carrier_out});
      end
      tx_en = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (tx_done !== 1'b0 || tx_busy !== 1'b0) bad_cycles++;
      end
      n_cmp++;
      if (bad_cycles !== 0) begin
         n_bad++;
         $display("FAIL rst_mid_hold: got %0d cycles with done/busy set, want 0", bad_cycles);
      end
      rstn = 1'b1;
      exp_q.push_back(mk("rst_mid_after", 0, -1, 0, 1'b0, 1'b0));
      for (int i = 0; i < 2 * BC && !found; i++) begin
         @(negedge clk);
         n++;
         if (tx_req === 1'b1) found = 1'b1;
      end
      n_cmp++;
      if (!found || n !== REQ_POS + 1) begin
         n_bad++;
         $display("FAIL rst_mid_req: got first tx_req after %0d cycles (found=%0b), want %0d",
                  n, found, REQ_POS + 1);
      end
      drain("rst_mid_after");
   endtask

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_idle();
      test_carrier();
      test_frame_zxyzz();
      test_xx_spacing();
      test_sample_hold();
      test_one_bit();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nfca_tx_modulate.md
NFCA_TX_MODULATE -- requirements
Module: nfca_tx_modulate

Interface
REQ-001 SHALL have parameter BIT_CLKS, default 768, clk cycles per bit period (128 carrier cycles at 13.56 MHz).
REQ-002 SHALL have parameter PAUSE_CLKS, default 192, pause width in clk cycles; legal range 1..BIT_CLKS/2-1, elaboration error otherwise.
REQ-003 SHALL have parameter REQ_LEAD, default 4, clk cycles between the tx_req pulse and the bit sample.
REQ-004 SHALL have port clk, input, 1 bit, 81.36 MHz system clock.
REQ-005 SHALL have port rstn, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port tx_req, output, 1 bit, one-cycle request for the next bit from the upstream framer.
REQ-007 SHALL have port tx_en, input, 1 bit, 1 = bit valid, 0 = no transmission.
REQ-008 SHALL have port tx_bit, input, 1 bit, logic value of the bit to send.
REQ-009 SHALL have port tx_pause, output, 1 bit, 1 = carrier off (Modified Miller pause).
REQ-010 SHALL have port carrier_out, output, 1 bit, gated 13.56 MHz carrier.
REQ-011 SHALL have port tx_busy, output, 1 bit, 1 while a frame is on air.
REQ-012 SHALL have port tx_done, output, 1 bit, one-cycle pulse at end of frame.

Function
REQ-013 SHALL run a free-running period counter cnt 0..BIT_CLKS-1 that wraps to 0, independent of traffic.
REQ-014 SHALL pulse tx_req for exactly one cycle when cnt==BIT_CLKS-1-REQ_LEAD, every period, including when idle.
REQ-015 SHALL sample tx_en and tx_bit only at cnt==BIT_CLKS-1; changes at any other time are ignored; tx_bit is ignored when tx_en=0.
REQ-016 SHALL encode each sampled bit in the following period: bit 1 -> SEQ_X; bit 0 with previous on-air bit 1 -> SEQ_Y; any other bit 0, including the first bit after idle -> SEQ_Z; tx_en=0 -> SEQ_IDLE.
REQ-017 SHALL drive tx_pause=1 for exactly PAUSE_CLKS consecutive cycles: starting at cnt==0 for SEQ_Z, starting at cnt==BIT_CLKS/2 for SEQ_X, and never for SEQ_Y or SEQ_IDLE.
REQ-018 SHALL hold the previous-bit state at 0 while idle, so every frame starts with SEQ_Z.
REQ-019 SHALL assert tx_busy from the first cycle of the first non-idle period through the last cycle of the first idle period after the frame (the trailing SEQ_Y).
REQ-020 SHALL pulse tx_done on the cycle tx_busy falls; an isolated one-bit frame still yields one tx_done.
REQ-021 SHALL make tx_pause, tx_busy, tx_done and tx_req registered outputs.

Reset
REQ-022 SHALL, while rstn=0, force cnt=0, tx_req=0, tx_pause=0, carrier_out=0, tx_busy=0, tx_done=0, previous-bit=0, and sequence=SEQ_IDLE, immediately and asynchronously.
REQ-023 SHALL, on reset mid-pause or mid-frame, abandon the frame with no tx_done and restart cnt from 0 on the first clk after release.

Configuration
REQ-024 SHALL, with macro NFCA_TX_CARRIER_EN defined, drive carrier_out as clk/6 (high 3 cycles, low 3 cycles, phase counter reset to 0) and force it 0 whenever tx_pause=1.
REQ-025 SHALL, without NFCA_TX_CARRIER_EN, tie carrier_out to constant 0 and omit the phase counter.

Structure
REQ-026 SHALL place BIT_CLKS and PAUSE_CLKS defaults and enum seq_t {SEQ_IDLE, SEQ_X, SEQ_Y, SEQ_Z} in shared package nfca_pkg.
REQ-027 SHALL implement the carrier divider/gate as sub-module nfca_carrier_gen, instantiated only under NFCA_TX_CARRIER_EN.

Verification
REQ-028 SHALL verify: idle with tx_en=0 for 5 periods -> tx_req pulses at cnt 763 every 768 cycles; tx_pause, tx_busy and tx_done stay 0.
REQ-029 SHALL verify: bits 0,1,0,0,0 (tx_en=1), then tx_en=0 -> sequences Z,X,Y,Z,Z,IDLE; pause starts at offsets 0,384,none,0,0, each 192 cycles wide; tx_busy spans 6 periods; one tx_done.
REQ-030 SHALL verify: bits 0,1,1,0 -> Z,X,X,Y; two pauses at offset 384, exactly 768 cycles apart.
REQ-031 SHALL verify: rstn low at cnt 100 of a SEQ_Z period -> tx_pause 0 in the same cycle, no tx_done; after release the first tx_req occurs 764 cycles later.
REQ-032 SHALL verify: tx_bit toggled at cnt 200 with tx_en=1 -> encoding unchanged until the next sample.
REQ-033 SHALL verify, with NFCA_TX_CARRIER_EN: carrier_out period 6 cycles; exactly 32 carrier periods suppressed per 192-cycle pause.
